// File: rtl/vend_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : vend_ctrl_fsm
// Description : Transaction controller for the micro vending machine.
//               Sequences item selection, coin payment, change return and
//               the post-sale display hold; all outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_ctrl_fsm #(
  parameter int PRICE_HIGH    = 5,
  parameter int PRICE_LOW     = 2,
  parameter int CHANGE_CYCLES = 100_000_000,
  parameter int TEMP_CYCLES   = 100_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start_key,
  input  logic [5:0] item_key,
  input  logic       confirm_key,
  input  logic       cancel_key,
  input  logic       coin_1,
  input  logic       coin_5,
  input  logic       coin_10,
  output logic [5:0] state,
  output logic [2:0] goods_high,
  output logic [2:0] goods_low,
  output logic [1:0] goods_num,
  output logic [4:0] money,
  output logic [4:0] change,
  output logic       dispense,
  output logic       coin_reject
);

  // One-hot encoding is also the value shown on the state bus.
  typedef enum logic [5:0] {
    S_IDLE      = 6'h01,
    S_GOODS_ONE = 6'h02,
    S_GOODS_TWO = 6'h04,
    S_PAYMENT   = 6'h08,
    S_CHANGE    = 6'h10,
    S_TEMP      = 6'h20
  } state_t;

  localparam logic [5:0]  c_price_high  = 6'(PRICE_HIGH);
  localparam logic [5:0]  c_price_low   = 6'(PRICE_LOW);
  localparam logic [31:0] c_change_last = 32'(CHANGE_CYCLES - 1);
  localparam logic [31:0] c_temp_last   = 32'(TEMP_CYCLES - 1);

  state_t      r_state,       w_state_nxt;
  logic [2:0]  r_goods_high,  w_goods_high_nxt;
  logic [2:0]  r_goods_low,   w_goods_low_nxt;
  logic [1:0]  r_goods_num,   w_goods_num_nxt;
  logic [4:0]  r_money,       w_money_nxt;
  logic [4:0]  r_change,      w_change_nxt;
  logic [5:0]  r_total,       w_total_nxt;
  logic [31:0] r_timer,       w_timer_nxt;
  logic        r_dispense,    w_dispense_nxt;
  logic        r_coin_reject, w_coin_reject_nxt;

  logic        w_item_valid;
  logic [5:0]  w_item_price;
  logic [5:0]  w_coin_sum;
  logic [5:0]  w_money_sum;
  logic        w_any_coin;
  logic        w_paid;

  // Decode item key, coin value of this cycle and the payment-complete test.
  always_comb begin
    w_item_valid = (item_key != 6'd0) && ((item_key & (item_key - 6'd1)) == 6'd0);
    w_item_price = (item_key[5:3] != 3'd0) ? c_price_high : c_price_low;
    w_coin_sum   = (coin_1  ? 6'd1  : 6'd0) +
                   (coin_5  ? 6'd5  : 6'd0) +
                   (coin_10 ? 6'd10 : 6'd0);
    w_money_sum  = {1'b0, r_money} + w_coin_sum;
    w_any_coin   = coin_1 | coin_5 | coin_10;
    w_paid       = ({1'b0, r_money} >= r_total);
  end

  // Next-state and next-output logic; cancel outranks confirm outranks item.
  always_comb begin
    w_state_nxt       = r_state;
    w_goods_high_nxt  = r_goods_high;
    w_goods_low_nxt   = r_goods_low;
    w_goods_num_nxt   = r_goods_num;
    w_money_nxt       = r_money;
    w_change_nxt      = r_change;
    w_total_nxt       = r_total;
    w_dispense_nxt    = 1'b0;
    w_coin_reject_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start_key) begin
          w_state_nxt      = S_GOODS_ONE;
          w_goods_high_nxt = 3'd0;
          w_goods_low_nxt  = 3'd0;
          w_goods_num_nxt  = 2'd0;
          w_money_nxt      = 5'd0;
          w_change_nxt     = 5'd0;
          w_total_nxt      = 6'd0;
        end
      end

      S_GOODS_ONE: begin
        if (cancel_key) begin
          w_state_nxt      = S_IDLE;
          w_goods_high_nxt = 3'd0;
          w_goods_low_nxt  = 3'd0;
          w_goods_num_nxt  = 2'd0;
          w_total_nxt      = 6'd0;
        end else if (confirm_key) begin
          // An empty basket cannot be paid for; the confirm is dropped.
          if (r_goods_num != 2'd0) w_state_nxt = S_PAYMENT;
        end else if (w_item_valid) begin
          w_goods_high_nxt = r_goods_high | item_key[5:3];
          w_goods_low_nxt  = r_goods_low  | item_key[2:0];
          w_total_nxt      = r_total + w_item_price;
          if (r_goods_num == 2'd0) begin
            w_goods_num_nxt = 2'd1;
          end else begin
            w_goods_num_nxt = 2'd2;
            w_state_nxt     = S_GOODS_TWO;
          end
        end
      end

      S_GOODS_TWO: begin
        if (cancel_key) begin
          w_state_nxt      = S_IDLE;
          w_goods_high_nxt = 3'd0;
          w_goods_low_nxt  = 3'd0;
          w_goods_num_nxt  = 2'd0;
          w_total_nxt      = 6'd0;
        end else if (confirm_key) begin
          w_state_nxt = S_PAYMENT;
        end
      end

      S_PAYMENT: begin
        if (cancel_key) begin
          // Full refund of everything inserted so far.
          w_state_nxt       = S_CHANGE;
          w_change_nxt      = r_money;
          w_coin_reject_nxt = w_any_coin;
        end else if (w_paid) begin
          w_state_nxt       = S_CHANGE;
          w_change_nxt      = r_money - r_total[4:0];
          w_dispense_nxt    = 1'b1;
          w_coin_reject_nxt = w_any_coin;
        end else if (w_money_sum <= 6'd31) begin
          w_money_nxt = w_money_sum[4:0];
        end else begin
          // Credit would overflow the 5-bit display: refuse every coin this cycle.
          w_coin_reject_nxt = 1'b1;
        end
      end

      S_CHANGE: begin
        w_coin_reject_nxt = w_any_coin;
        if (r_timer == c_change_last) w_state_nxt = S_TEMP;
      end

      S_TEMP: begin
        w_coin_reject_nxt = w_any_coin;
        if (r_timer == c_temp_last) begin
          w_state_nxt      = S_IDLE;
          w_goods_high_nxt = 3'd0;
          w_goods_low_nxt  = 3'd0;
          w_goods_num_nxt  = 2'd0;
          w_money_nxt      = 5'd0;
          w_change_nxt     = 5'd0;
          w_total_nxt      = 6'd0;
        end
      end

      default: begin
        // Corrupted state register: fall back to a clean idle machine.
        w_state_nxt      = S_IDLE;
        w_goods_high_nxt = 3'd0;
        w_goods_low_nxt  = 3'd0;
        w_goods_num_nxt  = 2'd0;
        w_money_nxt      = 5'd0;
        w_change_nxt     = 5'd0;
        w_total_nxt      = 6'd0;
      end
    endcase

    // Timer restarts on every state entry and only runs in the timed states.
    if (w_state_nxt != r_state) begin
      w_timer_nxt = 32'd0;
    end else if ((r_state == S_CHANGE) || (r_state == S_TEMP)) begin
      w_timer_nxt = r_timer + 32'd1;
    end else begin
      w_timer_nxt = r_timer;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= S_IDLE;
      r_goods_high  <= 3'd0;
      r_goods_low   <= 3'd0;
      r_goods_num   <= 2'd0;
      r_money       <= 5'd0;
      r_change      <= 5'd0;
      r_total       <= 6'd0;
      r_timer       <= 32'd0;
      r_dispense    <= 1'b0;
      r_coin_reject <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_goods_high  <= w_goods_high_nxt;
      r_goods_low   <= w_goods_low_nxt;
      r_goods_num   <= w_goods_num_nxt;
      r_money       <= w_money_nxt;
      r_change      <= w_change_nxt;
      r_total       <= w_total_nxt;
      r_timer       <= w_timer_nxt;
      r_dispense    <= w_dispense_nxt;
      r_coin_reject <= w_coin_reject_nxt;
    end
  end

  assign state       = r_state;
  assign goods_high  = r_goods_high;
  assign goods_low   = r_goods_low;
  assign goods_num   = r_goods_num;
  assign money       = r_money;
  assign change      = r_change;
  assign dispense    = r_dispense;
  assign coin_reject = r_coin_reject;

endmodule
`default_nettype wire
